// File: rtl/vga_pkg.sv
// Shared timing defaults and width helpers for the VGA timing generator.
package vga_pkg;

    // 640x480 @ 60 Hz timing, 25 MHz pixel rate
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Ceiling log2, evaluated at elaboration time for counter widths
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Counter width that never collapses to zero bits (e.g. a divide-by-1)
    function automatic int cnt_width(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): a wrapping position counter
// plus decode of the visible area and the sync window.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int W      = cnt_width(ACTIVE + FP + SYNC + BP)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    input  logic         clear,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync_on
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    // Window bounds carry one spare bit so an end bound equal to 2**W
    // (zero back porch on a power-of-two total) does not truncate to 0.
    localparam logic [W:0] ACT_END  = (W+1)'(ACTIVE);
    localparam logic [W:0] SYNC_BEG = (W+1)'(ACTIVE + FP);
    localparam logic [W:0] SYNC_END = (W+1)'(ACTIVE + FP + SYNC);

    logic [W:0] count_ext;

    assign count_ext = {1'b0, count};
    assign wrap      = step && (count == LAST);
    assign active    = (count_ext < ACT_END);
    assign sync_on   = (count_ext >= SYNC_BEG) && (count_ext < SYNC_END);

    // Position register: cleared when idle, advances one step, wraps exactly at TOTAL-1
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is assigned with <= so every register in the
        // design samples the same pre-edge values regardless of block order.
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (step) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator and registered pixel-output stage.
// Produces a pixel strobe from clk, walks the h/v raster, asks the paint
// logic for a colour at each coordinate and registers colour and syncs
// onto the pins one pixel period later with blanking applied.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   CLK_DIV  = 4,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   R_W      = 3,
    parameter int   G_W      = 3,
    parameter int   B_W      = 2,
    localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  H_W      = cnt_width(H_TOTAL),
    localparam int  V_W      = cnt_width(V_TOTAL)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic [R_W-1:0] pix_r,
    input  logic [G_W-1:0] pix_g,
    input  logic [B_W-1:0] pix_b,
    output logic [H_W-1:0] pixel_x,
    output logic [V_W-1:0] pixel_y,
    output logic           pix_req,
    output logic           pix_ce,
    output logic           frame_start,
    output logic           line_start,
    output logic [R_W-1:0] vgaRed,
    output logic [G_W-1:0] vgaGreen,
    output logic [B_W-1:0] vgaBlue,
    output logic           Hsync,
    output logic           Vsync
);

    localparam int DIV_W = cnt_width(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             h_wrap;
    logic             h_active;
    logic             h_sync_on;
    logic             v_active;
    logic             v_sync_on;
    logic             v_wrap_unused;  // frame wrap is already visible as v returning to 0
    logic             in_active;

    // Pixel strobe: with CLK_DIV=1 the divider sits at its last count, so
    // rst_n gates the strobe to keep the handshake outputs low during reset.
    assign pix_ce = rst_n && enable && (div_cnt == DIV_LAST);

    // Clock divider: counts 0..CLK_DIV-1 while running, parked at 0 when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!enable || (div_cnt == DIV_LAST)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (H_W)
    ) u_h_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (pix_ce),
        .clear   (!enable),
        .count   (pixel_x),
        .wrap    (h_wrap),
        .active  (h_active),
        .sync_on (h_sync_on)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (V_W)
    ) u_v_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (h_wrap),
        .clear   (!enable),
        .count   (pixel_y),
        .wrap    (v_wrap_unused),
        .active  (v_active),
        .sync_on (v_sync_on)
    );

    assign in_active   = h_active && v_active;
    assign pix_req     = pix_ce && in_active;
    assign line_start  = pix_ce && (pixel_x == '0);
    assign frame_start = line_start && (pixel_y == '0);

    // Pin register: samples colour and sync decode on the strobe that ends the
    // pixel period, so colour and syncs stay aligned one pixel behind the counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vgaRed   <= '0;
            vgaGreen <= '0;
            vgaBlue  <= '0;
            Hsync    <= ~HS_POL;
            Vsync    <= ~VS_POL;
        end else if (!enable) begin
            vgaRed   <= '0;
            vgaGreen <= '0;
            vgaBlue  <= '0;
            Hsync    <= ~HS_POL;
            Vsync    <= ~VS_POL;
        end else if (pix_ce) begin
            vgaRed   <= in_active ? pix_r : '0;
            vgaGreen <= in_active ? pix_g : '0;
            vgaBlue  <= in_active ? pix_b : '0;
            Hsync    <= h_sync_on ? HS_POL : ~HS_POL;
            Vsync    <= v_sync_on ? VS_POL : ~VS_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen. Two small-raster instances
// (divide-by-1 with low syncs, divide-by-3 with high syncs) are checked
// every clk against a raster model computed from elapsed pixel count;
// a default-timing instance is measured for line timing.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 1;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;  // 14
    localparam int VT = VA + VF + VS + VB;  // 7

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Small-raster instances: index 0 = CLK_DIV 1, low syncs; 1 = CLK_DIV 3, high syncs
    logic       en_i   [2];
    logic [2:0] r_i    [2];
    logic [2:0] g_i    [2];
    logic [1:0] b_i    [2];
    logic       follow;
    logic [3:0] x_o    [2];
    logic [2:0] y_o    [2];
    logic       req_o  [2];
    logic       ce_o   [2];
    logic       fs_o   [2];
    logic       ls_o   [2];
    logic [2:0] red_o  [2];
    logic [2:0] grn_o  [2];
    logic [1:0] blu_o  [2];
    logic       hs_o   [2];
    logic       vs_o   [2];

    // Default-timing instance
    logic       en_c;
    logic [9:0] x_c, y_c;
    logic       req_c, ce_c, fs_c, ls_c, hs_c, vs_c;
    logic [2:0] red_c, grn_c;
    logic [1:0] blu_c;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_i[0]),
        .pix_r(follow ? x_o[0][2:0] : r_i[0]), .pix_g(g_i[0]), .pix_b(b_i[0]),
        .pixel_x(x_o[0]), .pixel_y(y_o[0]), .pix_req(req_o[0]), .pix_ce(ce_o[0]),
        .frame_start(fs_o[0]), .line_start(ls_o[0]),
        .vgaRed(red_o[0]), .vgaGreen(grn_o[0]), .vgaBlue(blu_o[0]),
        .Hsync(hs_o[0]), .Vsync(vs_o[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(3), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_i[1]),
        .pix_r(r_i[1]), .pix_g(g_i[1]), .pix_b(b_i[1]),
        .pixel_x(x_o[1]), .pixel_y(y_o[1]), .pix_req(req_o[1]), .pix_ce(ce_o[1]),
        .frame_start(fs_o[1]), .line_start(ls_o[1]),
        .vgaRed(red_o[1]), .vgaGreen(grn_o[1]), .vgaBlue(blu_o[1]),
        .Hsync(hs_o[1]), .Vsync(vs_o[1])
    );

    vga_timing_gen dut_c (
        .clk(clk), .rst_n(rst_n), .enable(en_c),
        .pix_r(3'd5), .pix_g(3'd2), .pix_b(2'd1),
        .pixel_x(x_c), .pixel_y(y_c), .pix_req(req_c), .pix_ce(ce_c),
        .frame_start(fs_c), .line_start(ls_c),
        .vgaRed(red_c), .vgaGreen(grn_c), .vgaBlue(blu_c),
        .Hsync(hs_c), .Vsync(vs_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: k = clks spent enabled since the last clear.
    // Pixel index is k / CLK_DIV; h and v follow by plain division.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        logic       hs;
        logic       vs;
    } pins_t;

    int    k_m    [2];
    int    last_k [2];
    pins_t pins_m [2];
    int    req_cnt_b;
    int    ce_cnt_b;

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic pol_of(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic pins_t idle_pins(input int i);
        pins_t p;
        p.r  = '0;
        p.g  = '0;
        p.b  = '0;
        p.hs = ~pol_of(i);
        p.vs = ~pol_of(i);
        return p;
    endfunction

    // One clk: drive inputs just after the edge, check at the falling edge, advance model
    task automatic tick(input bit ea, input bit eb, input bit fol);
        int    p, h, v, d;
        bit    en, ce, act;
        string nm;
        pins_t pm;
        @(posedge clk);
        #1;
        en_i[0] = ea;
        en_i[1] = eb;
        follow  = fol;
        for (int i = 0; i < 2; i++) begin
            r_i[i] = 3'($urandom);
            g_i[i] = 3'($urandom);
            b_i[i] = 2'($urandom);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            nm  = (i == 0) ? "a" : "b";
            en  = (i == 0) ? ea : eb;
            d   = div_of(i);
            p   = k_m[i] / d;
            h   = p % HT;
            v   = (p / HT) % VT;
            ce  = en && ((k_m[i] % d) == d - 1);
            act = (h < HA) && (v < VA);
            check({nm, ".pixel_x"},     x_o[i],   h);
            check({nm, ".pixel_y"},     y_o[i],   v);
            check({nm, ".pix_ce"},      ce_o[i],  ce);
            check({nm, ".pix_req"},     req_o[i], ce && act);
            check({nm, ".line_start"},  ls_o[i],  ce && (h == 0));
            check({nm, ".frame_start"}, fs_o[i],  ce && (h == 0) && (v == 0));
            check({nm, ".vgaRed"},      red_o[i], pins_m[i].r);
            check({nm, ".vgaGreen"},    grn_o[i], pins_m[i].g);
            check({nm, ".vgaBlue"},     blu_o[i], pins_m[i].b);
            check({nm, ".Hsync"},       hs_o[i],  pins_m[i].hs);
            check({nm, ".Vsync"},       vs_o[i],  pins_m[i].vs);
            if (i == 1) begin
                req_cnt_b += int'(req_o[1]);
                ce_cnt_b  += int'(ce_o[1]);
            end
            last_k[i] = k_m[i];
            if (!en) begin
                k_m[i]    = 0;
                pins_m[i] = idle_pins(i);
            end else begin
                if (ce) begin
                    pm.r  = act ? (((i == 0) && fol) ? 3'(h) : r_i[i]) : 3'd0;
                    pm.g  = act ? g_i[i] : 3'd0;
                    pm.b  = act ? b_i[i] : 2'd0;
                    pm.hs = ((h >= HA + HF) && (h < HA + HF + HS)) ? pol_of(i) : ~pol_of(i);
                    pm.vs = ((v >= VA + VF) && (v < VA + VF + VS)) ? pol_of(i) : ~pol_of(i);
                    pins_m[i] = pm;
                end
                k_m[i]++;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, ".x"},    x_o[i],   0);
            check({tag, ".y"},    y_o[i],   0);
            check({tag, ".ce"},   ce_o[i],  0);
            check({tag, ".req"},  req_o[i], 0);
            check({tag, ".ls"},   ls_o[i],  0);
            check({tag, ".fs"},   fs_o[i],  0);
            check({tag, ".rgb"},  {red_o[i], grn_o[i], blu_o[i]}, 0);
            check({tag, ".hs"},   hs_o[i],  (i == 0) ? 1 : 0);
            check({tag, ".vs"},   vs_o[i],  (i == 0) ? 1 : 0);
        end
    endtask

    // First frame of instance a with pix_r following pixel_x
    typedef struct {
        int k;
        int x;
        int y;
        bit req;
        bit ls;
        bit fs;
        int red;
        bit hs;
        bit vs;
    } vec_t;

    vec_t tbl [19];

    initial begin
        int guard;
        int fall1, fall2, rise1, fs_at, n;
        logic hs_prev;

        tbl[0]  = '{0,  0,  0, 1, 1, 1, 0, 1, 1};
        tbl[1]  = '{1,  1,  0, 1, 0, 0, 0, 1, 1};
        tbl[2]  = '{5,  5,  0, 1, 0, 0, 4, 1, 1};
        tbl[3]  = '{8,  8,  0, 0, 0, 0, 7, 1, 1};
        tbl[4]  = '{9,  9,  0, 0, 0, 0, 0, 1, 1};
        tbl[5]  = '{10, 10, 0, 0, 0, 0, 0, 1, 1};
        tbl[6]  = '{11, 11, 0, 0, 0, 0, 0, 0, 1};
        tbl[7]  = '{13, 13, 0, 0, 0, 0, 0, 0, 1};
        tbl[8]  = '{14, 0,  1, 1, 1, 0, 0, 1, 1};
        tbl[9]  = '{16, 2,  1, 1, 0, 0, 1, 1, 1};
        tbl[10] = '{50, 8,  3, 0, 0, 0, 7, 1, 1};
        tbl[11] = '{55, 13, 3, 0, 0, 0, 0, 0, 1};
        tbl[12] = '{59, 3,  4, 0, 0, 0, 0, 1, 1};
        tbl[13] = '{70, 0,  5, 0, 1, 0, 0, 1, 1};
        tbl[14] = '{71, 1,  5, 0, 0, 0, 0, 1, 0};
        tbl[15] = '{84, 0,  6, 0, 1, 0, 0, 1, 0};
        tbl[16] = '{85, 1,  6, 0, 0, 0, 0, 1, 1};
        tbl[17] = '{98, 0,  0, 1, 1, 1, 0, 1, 1};
        tbl[18] = '{99, 1,  0, 1, 0, 0, 0, 1, 1};

        en_i[0] = 1'b0;
        en_i[1] = 1'b0;
        en_c    = 1'b0;
        follow  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r_i[i]    = '0;
            g_i[i]    = '0;
            b_i[i]    = '0;
            k_m[i]    = 0;
            last_k[i] = 0;
            pins_m[i] = idle_pins(i);
        end
        req_cnt_b = 0;
        ce_cnt_b  = 0;

        // Power-on reset values
        #12;
        check_reset_values("rst");
        check("rst.c.hs", hs_c, 1);
        check("rst.c.vs", vs_c, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed first frame, pix_r = pixel_x[2:0]
        for (int e = 0; e < 19; e++) begin
            guard = 0;
            do begin
                tick(1'b1, 1'b0, 1'b1);
                guard++;
            end while ((last_k[0] < tbl[e].k) && (guard < 200));
            check("tbl.k",      last_k[0], tbl[e].k);
            check("tbl.x",      x_o[0],    tbl[e].x);
            check("tbl.y",      y_o[0],    tbl[e].y);
            check("tbl.req",    req_o[0],  tbl[e].req);
            check("tbl.ls",     ls_o[0],   tbl[e].ls);
            check("tbl.fs",     fs_o[0],   tbl[e].fs);
            check("tbl.red",    red_o[0],  tbl[e].red);
            check("tbl.hs",     hs_o[0],   tbl[e].hs);
            check("tbl.vs",     vs_o[0],   tbl[e].vs);
        end

        // Random colours with occasional enable drops on both instances
        for (int n_r = 0; n_r < 1500; n_r++) begin
            tick($urandom_range(0, 15) != 0, $urandom_range(0, 15) != 0, 1'b0);
        end

        // Enable dropped mid-line for 3 clks, then raised again
        guard = 0;
        do begin
            tick(1'b1, 1'b1, 1'b0);
            guard++;
        end while (!((x_o[0] == 4'd4) && (y_o[0] == 3'd2)) && (guard < 300));
        check("drop.found_h4_v2", (guard < 300), 1);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        check("drop.a.x",   x_o[0],  0);
        check("drop.a.y",   y_o[0],  0);
        check("drop.a.hs",  hs_o[0], 1);
        check("drop.a.red", red_o[0], 0);
        check("drop.b.x",   x_o[1],  0);
        check("drop.b.hs",  hs_o[1], 0);
        tick(1'b1, 1'b1, 1'b0);
        check("reen.a.fs0", fs_o[0], 1);
        check("reen.b.fs0", fs_o[1], 0);
        tick(1'b1, 1'b1, 1'b0);
        check("reen.a.fs1", fs_o[0], 0);
        check("reen.b.fs1", fs_o[1], 0);
        tick(1'b1, 1'b1, 1'b0);
        check("reen.b.fs2", fs_o[1], 1);

        // Asynchronous reset in the middle of an active line
        guard = 0;
        do begin
            tick(1'b1, 1'b1, 1'b0);
            guard++;
        end while (!((x_o[0] == 4'd3) && (y_o[0] == 3'd1)) && (guard < 300));
        check("arst.found_h3_v1", (guard < 300), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("arst");
        en_i[0] = 1'b0;
        en_i[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            k_m[i]    = 0;
            pins_m[i] = idle_pins(i);
        end

        // One full frame on the divide-by-3 instance
        req_cnt_b = 0;
        ce_cnt_b  = 0;
        repeat (3 * HT * VT) tick(1'b1, 1'b1, 1'b0);
        check("b.pix_req_per_frame", req_cnt_b, HA * VA);
        check("b.pix_ce_per_frame",  ce_cnt_b,  HT * VT);

        // Default 640x480 timing: line period and sync width in clks
        en_i[0] = 1'b0;
        en_i[1] = 1'b0;
        @(posedge clk);
        #1;
        en_c    = 1'b1;
        fall1   = -1;
        fall2   = -1;
        rise1   = -1;
        fs_at   = -1;
        hs_prev = 1'b1;
        n       = 0;
        while ((fall2 < 0) && (n < 12000)) begin
            @(negedge clk);
            if (fs_c && (fs_at < 0)) fs_at = n;
            if (hs_prev && !hs_c) begin
                if (fall1 < 0) fall1 = n;
                else           fall2 = n;
            end
            if (!hs_prev && hs_c && (rise1 < 0)) rise1 = n;
            hs_prev = hs_c;
            n++;
        end
        check("c.within_budget",   (fall2 >= 0), 1);
        check("c.first_fs_clk",    fs_at, 3);
        check("c.first_hs_fall",   fall1, 2628);
        check("c.hs_period_clks",  fall2 - fall1, 3200);
        check("c.hs_low_clks",     rise1 - fall1, 384);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
